// File: rtl/scope_capture_pkg.sv
// Shared types and sizing for the scope capture block.
//   state_e    : capture FSM states (IDLE, ARMED, CAPTURE, HOLD)
//   FRAME_LEN  : frame length for the default 8-bit address width
//   frame_len(): frame length for any address width
package scope_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_e;

  localparam int unsigned DEF_ADDRESS_WIDTH = 8;
  localparam int unsigned FRAME_LEN         = 1 << DEF_ADDRESS_WIDTH;

  function automatic int unsigned frame_len(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/scope_capture_ram.sv
// Frame buffer for scope_capture: one synchronous write port and one
// registered read port. A read and a write to the same address in the same
// cycle return the old contents. Memory contents are not reset; only the read
// register is.
//   clk, rst   : clock, async active-low reset (read register only)
//   we_i       : write enable
//   waddr_i    : write address
//   wdata_i    : write data
//   raddr_i    : read address
//   rdata_o    : read data, one cycle after raddr_i
module capture_ram #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we_i,
  input  logic [ADDRESS_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  input  logic [ADDRESS_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0]    rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDRESS_WIDTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdata_o <= '0;
    else      rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/scope_capture.sv
// Triggered sample capture. Waits for a rising crossing of trig_level on the
// en-qualified sample stream, then stores 2^ADDRESS_WIDTH consecutive samples
// (triggering sample at address 0) and holds them until re-armed.
//   clk, rst    : clock, async active-low reset
//   en, din     : sample strobe and sample
//   trig_level  : unsigned trigger threshold
//   arm         : start waiting for a trigger (ignored while busy)
//   rd_addr     : readout address
//   rd_data     : registered readout data (1-cycle latency)
//   busy, done  : ARMED|CAPTURE, HOLD
//   auto_trig   : frame forced by timeout
// Build option: define SCOPE_AUTOTRIG_EN to force a capture after
// 2^ADDRESS_WIDTH armed samples without a crossing.
module scope_capture
  import scope_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic [DATA_WIDTH-1:0]    trig_level,
  input  logic                     arm,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     busy,
  output logic                     done,
  output logic                     auto_trig
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = '1;

  state_e                   state_q, state_d;
  logic [DATA_WIDTH-1:0]    prev_q, prev_d;
  logic                     prev_valid_q, prev_valid_d;
  logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic                     busy_q, done_q;

  logic                     we;
  logic [ADDRESS_WIDTH-1:0] waddr;
  logic                     crossing;
  logic                     force_trig;

`ifdef SCOPE_AUTOTRIG_EN
  localparam int CNT_W = ADDRESS_WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(frame_len(ADDRESS_WIDTH));
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             auto_q, auto_d;
  assign auto_trig = auto_q;
`else
  assign auto_trig = 1'b0;
`endif

  // The first sample after arm has no valid predecessor, so it cannot trigger.
  assign crossing = prev_valid_q && (prev_q < trig_level) && (din >= trig_level);

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    wr_ptr_d     = wr_ptr_q;
    we           = 1'b0;
    waddr        = wr_ptr_q;
`ifdef SCOPE_AUTOTRIG_EN
    cnt_d        = cnt_q;
    auto_d       = auto_q;
    force_trig   = (cnt_q == CNT_FULL);
`else
    force_trig   = 1'b0;
`endif
    unique case (state_q)
      IDLE, HOLD: begin
        if (arm) begin
          state_d      = ARMED;
          prev_valid_d = 1'b0;
`ifdef SCOPE_AUTOTRIG_EN
          cnt_d        = '0;
          auto_d       = 1'b0;
`endif
        end
      end
      ARMED: begin
        if (en) begin
          prev_d       = din;
          prev_valid_d = 1'b1;
          if (crossing || force_trig) begin
            // Triggering sample lands at address 0 in this same cycle.
            we       = 1'b1;
            waddr    = '0;
            wr_ptr_d = ADDRESS_WIDTH'(1);
            state_d  = CAPTURE;
          end
`ifdef SCOPE_AUTOTRIG_EN
          // A genuine crossing wins over the timeout.
          if (!crossing && force_trig) auto_d = 1'b1;
          if (!(crossing || force_trig)) cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      CAPTURE: begin
        if (en) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + ADDRESS_WIDTH'(1);
          if (wr_ptr_q == LAST_ADDR) state_d = HOLD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      wr_ptr_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef SCOPE_AUTOTRIG_EN
      cnt_q        <= '0;
      auto_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      wr_ptr_q     <= wr_ptr_d;
      // Decode from next state so the flags line up with state_q.
      busy_q       <= (state_d == ARMED) || (state_d == CAPTURE);
      done_q       <= (state_d == HOLD);
`ifdef SCOPE_AUTOTRIG_EN
      cnt_q        <= cnt_d;
      auto_q       <= auto_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  capture_ram #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (din),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

endmodule

// File: tb/tb_scope_capture.sv
module tb_scope_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] trig_level = '0;
  logic       arm = 1'b0;
  logic [7:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       busy, done, auto_trig;

  int vectors = 0;
  int miscompares = 0;

  scope_capture #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .din        (din),
    .trig_level (trig_level),
    .arm        (arm),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .busy       (busy),
    .done       (done),
    .auto_trig  (auto_trig)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic e, input logic [7:0] d);
    en = e; din = d;
    tick();
    en = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      en = i[0]; din = 8'(i * 40); arm = (i == 2);
      tick();
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0 || rd_data !== 8'h00 || auto_trig !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_state cyc=%0d got busy=%b done=%b rd=%h at=%b want 0,0,00,0",
                 i, busy, done, rd_data, auto_trig);
      end
    end
    en = 1'b0; arm = 1'b0;
    rst = 1'b1;
    tick();
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset got busy=%b done=%b want 0,0", busy, done);
    end
  endtask

  task automatic test_basic_trigger();
    logic [7:0] addrs [5] = '{8'd0, 8'd1, 8'd127, 8'd128, 8'd255};
    trig_level = 8'd128;
    pulse_arm();
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL armed_flags got busy=%b done=%b want 1,0", busy, done);
    end
    // Trigger on din=128 (i=128); 256 writes end at i=383.
    for (int i = 0; i < 384; i++) begin
      sample(1'b1, 8'(i));
      if (i == 382 || i == 383) begin
        vectors++;
        if (done !== (i == 383) || busy !== (i != 383)) begin
          miscompares++;
          $display("FAIL basic_done i=%0d got done=%b busy=%b want %b,%b",
                   i, done, busy, (i == 383), (i != 383));
        end
      end
    end
    // HOLD ignores further samples.
    for (int i = 0; i < 5; i++) sample(1'b1, 8'hA5);
    foreach (addrs[j]) begin
      rd_addr = addrs[j];
      tick();
      vectors++;
      if (rd_data !== 8'(128 + int'(addrs[j]))) begin
        miscompares++;
        $display("FAIL basic_read addr=%0d got %h want %h", addrs[j], rd_data,
                 8'(128 + int'(addrs[j])));
      end
    end
  endtask

  task automatic test_first_sample_guard();
    trig_level = 8'd100;
    pulse_arm();
    for (int i = 0; i < 20; i++) sample(1'b1, 8'(200 + i));
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL guard_no_trig got busy=%b done=%b want 1,0", busy, done);
    end
    // 50 -> 100 is an exact-threshold crossing.
    sample(1'b1, 8'd50);
    sample(1'b1, 8'd100);
    for (int k = 1; k < 256; k++) begin
      sample(1'b1, 8'(k));
      if (k >= 254) begin
        vectors++;
        if (done !== (k == 255)) begin
          miscompares++;
          $display("FAIL guard_done k=%0d got %b want %b", k, done, (k == 255));
        end
      end
    end
    rd_addr = 8'd0; tick();
    vectors++;
    if (rd_data !== 8'd100) begin
      miscompares++;
      $display("FAIL guard_read0 got %h want 64", rd_data);
    end
    rd_addr = 8'd1; tick();
    vectors++;
    if (rd_data !== 8'd1) begin
      miscompares++;
      $display("FAIL guard_read1 got %h want 01", rd_data);
    end
  endtask

  task automatic test_gapped_enable();
    logic [7:0] addrs [3] = '{8'd1, 8'd100, 8'd255};
    trig_level = 8'd10;
    pulse_arm();
    sample(1'b1, 8'd9);
    sample(1'b1, 8'd10);
    for (int k = 1; k < 256; k++) begin
      sample(1'b0, 8'hEE);
      sample(1'b0, 8'hEE);
      vectors++;
      if (done !== 1'b0) begin
        miscompares++;
        $display("FAIL gap_done_early k=%0d got %b want 0", k, done);
      end
      sample(1'b1, 8'(10 + k));
    end
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL gap_done got done=%b busy=%b want 1,0", done, busy);
    end
    foreach (addrs[j]) begin
      rd_addr = addrs[j];
      tick();
      vectors++;
      if (rd_data !== 8'(10 + int'(addrs[j]))) begin
        miscompares++;
        $display("FAIL gap_read addr=%0d got %h want %h", addrs[j], rd_data,
                 8'(10 + int'(addrs[j])));
      end
    end
  endtask

  task automatic test_rearm_reset();
    trig_level = 8'd128;
    pulse_arm();
    for (int i = 0; i < 384; i++) begin
      arm = (i == 200 || i == 300);
      sample(1'b1, 8'(i));
    end
    arm = 1'b0;
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL rearm_ignored_done got %b want 1", done);
    end
    rd_addr = 8'd200; tick();
    vectors++;
    if (rd_data !== 8'd72) begin
      miscompares++;
      $display("FAIL rearm_read200 got %h want 48", rd_data);
    end
    pulse_arm();
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL rearm_from_hold got busy=%b done=%b want 1,0", busy, done);
    end
    for (int i = 0; i < 179; i++) sample(1'b1, 8'(i));
    rst = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || auto_trig !== 1'b0) begin
      miscompares++;
      $display("FAIL midcap_reset got busy=%b done=%b at=%b want 0,0,0", busy, done, auto_trig);
    end
    tick();
    rst = 1'b1;
    sample(1'b1, 8'd200);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_midreset got busy=%b done=%b want 0,0", busy, done);
    end
    trig_level = 8'd64;
    pulse_arm();
    for (int i = 60; i < 60 + 4 + 256; i++) sample(1'b1, 8'(i));
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL recapture_done got %b want 1", done);
    end
    rd_addr = 8'd0; tick();
    vectors++;
    if (rd_data !== 8'd64) begin
      miscompares++;
      $display("FAIL recapture_read0 got %h want 40", rd_data);
    end
    rd_addr = 8'd200; tick();
    vectors++;
    if (rd_data !== 8'd8) begin
      miscompares++;
      $display("FAIL recapture_read200 got %h want 08", rd_data);
    end
  endtask

  task automatic test_auto_trigger();
    trig_level = 8'd100;
    pulse_arm();
    for (int i = 0; i < 256; i++) sample(1'b1, 8'd50);
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0 || auto_trig !== 1'b0) begin
      miscompares++;
      $display("FAIL auto_wait got busy=%b done=%b at=%b want 1,0,0", busy, done, auto_trig);
    end
`ifdef SCOPE_AUTOTRIG_EN
    sample(1'b1, 8'd50);
    vectors++;
    if (auto_trig !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL auto_force got at=%b busy=%b want 1,1", auto_trig, busy);
    end
    for (int i = 0; i < 255; i++) sample(1'b1, 8'd50);
    vectors++;
    if (done !== 1'b1 || auto_trig !== 1'b1) begin
      miscompares++;
      $display("FAIL auto_done got done=%b at=%b want 1,1", done, auto_trig);
    end
    rd_addr = 8'd0; tick();
    vectors++;
    if (rd_data !== 8'd50) begin
      miscompares++;
      $display("FAIL auto_read0 got %h want 32", rd_data);
    end
    rd_addr = 8'd255; tick();
    vectors++;
    if (rd_data !== 8'd50) begin
      miscompares++;
      $display("FAIL auto_read255 got %h want 32", rd_data);
    end
    pulse_arm();
    vectors++;
    if (auto_trig !== 1'b0) begin
      miscompares++;
      $display("FAIL auto_clear got %b want 0", auto_trig);
    end
`else
    for (int i = 0; i < 300; i++) sample(1'b1, 8'd50);
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0 || auto_trig !== 1'b0) begin
      miscompares++;
      $display("FAIL no_auto got busy=%b done=%b at=%b want 1,0,0", busy, done, auto_trig);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic_trigger();
    test_first_sample_guard();
    test_gapped_enable();
    test_rearm_reset();
    test_auto_trigger();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
